// File: rtl/gtx_div_reset_seq_mc_if.sv
// GTX divider reset sequencer bus: lock/rate/enable in,
// GTXTEST drive and status out.
interface gtx_div_reset_seq_mc_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] plllkdet;
    logic [NCH-1:0] tx_rate;
    logic           ena;
    logic [NCH-1:0] restart;
    logic [NCH-1:0] gtxtest_bit1;
    logic [NCH-1:0] gtxtest_done;
    logic           all_done;
    logic           busy;

    modport master (
        output plllkdet, tx_rate, ena, restart,
        input  gtxtest_bit1, gtxtest_done, all_done, busy
    );

    modport slave (
        input  plllkdet, tx_rate, ena, restart,
        output gtxtest_bit1, gtxtest_done, all_done, busy
    );
endinterface

// File: rtl/gtx_div_reset_seq_mc.sv
// Multi-channel GTX TX clock-divider reset sequencer:
// lock wait, NPULSE GTXTEST[1] pulses, done flag per channel.
module gtx_div_reset_seq_mc #(
    parameter int NCH       = 4,
    parameter int LOCK_WAIT = 1024,
    parameter int PULSE_LEN = 256,
    parameter int GAP_LEN   = 256,
    parameter int NPULSE    = 2,
    parameter int CNT_W     = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gtx_div_reset_seq_mc_if.slave  bus
);
    localparam int PN_W = (NPULSE > 1) ? $clog2(NPULSE) : 1;
    localparam logic [CNT_W-1:0] LW_T = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] PL_T = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GL_T = CNT_W'(GAP_LEN - 1);
    localparam logic [PN_W-1:0]  PN_T = PN_W'(NPULSE - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT, PULSE, GAP, DONE
    } state_t;

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] lk_s;
    logic [NCH-1:0] rate_q;
    logic [NCH-1:0] qual;
    logic [NCH-1:0] kick;
    logic [NCH-1:0] bit1;
    logic [NCH-1:0] done;
    logic [NCH-1:0] busy_ch;
    logic           all_done_q;
    logic           busy_q;

    // PLLLKDET is asynchronous to clk; TX_RATE is already synchronous
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            lk_s   <= '0;
            rate_q <= '0;
        end else begin
            sync1  <= bus.plllkdet;
            lk_s   <= sync1;
            rate_q <= bus.tx_rate;
        end
    end

    assign qual = lk_s & {NCH{bus.ena}};
    assign kick = (bus.tx_rate ^ rate_q) | bus.restart;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           st;
        state_t           nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_n;
        logic [PN_W-1:0]  pnum;
        logic [PN_W-1:0]  pnum_n;
        logic             bit1_q;
        logic             done_q;

        // abort beats kick beats normal sequencing
        always_comb begin
            nxt    = st;
            cnt_n  = cnt;
            pnum_n = pnum;
            if (!qual[i]) begin
                nxt    = IDLE;
                cnt_n  = '0;
                pnum_n = '0;
            end else if (kick[i] && st != IDLE) begin
                nxt    = WAIT;
                cnt_n  = '0;
                pnum_n = '0;
            end else begin
                unique case (st)
                    IDLE: begin
                        nxt   = WAIT;
                        cnt_n = '0;
                    end
                    WAIT: begin
                        if (cnt == LW_T) begin
                            nxt    = PULSE;
                            cnt_n  = '0;
                            pnum_n = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    PULSE: begin
                        if (cnt == PL_T) begin
                            cnt_n = '0;
                            nxt   = (pnum == PN_T) ? DONE : GAP;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == GL_T) begin
                            nxt    = PULSE;
                            cnt_n  = '0;
                            pnum_n = pnum + 1'b1;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    DONE: ;
                    default: nxt = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st     <= IDLE;
                cnt    <= '0;
                pnum   <= '0;
                bit1_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                st     <= nxt;
                cnt    <= cnt_n;
                pnum   <= pnum_n;
                bit1_q <= (nxt == PULSE);
                done_q <= (nxt == DONE);
            end
        end

        assign bit1[i]    = bit1_q;
        assign done[i]    = done_q;
        assign busy_ch[i] = (st == WAIT) || (st == PULSE) || (st == GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            all_done_q <= &done;
            busy_q     <= |busy_ch;
        end
    end

    assign bus.gtxtest_bit1 = bit1;
    assign bus.gtxtest_done = done;
    assign bus.all_done     = all_done_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_gtx_div_reset_seq_mc.sv
// Directed bench for gtx_div_reset_seq_mc: NCH=2, LOCK_WAIT=16,
// PULSE_LEN=4, GAP_LEN=4, NPULSE=2.
module tb_gtx_div_reset_seq_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    gtx_div_reset_seq_mc_if #(.NCH(2)) bus ();

    gtx_div_reset_seq_mc #(
        .NCH(2), .LOCK_WAIT(16), .PULSE_LEN(4),
        .GAP_LEN(4), .NPULSE(2), .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #12 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // w = cycle index of first WAIT cycle
    function automatic logic pb(input int c, input int w);
        int d;
        d = c - w;
        return (d >= 16 && d < 20) || (d >= 24 && d < 28);
    endfunction

    function automatic logic pd(input int c, input int w);
        return (c - w) >= 28;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.plllkdet = '0;
        bus.tx_rate = '0;
        bus.ena = 1'b0;
        bus.restart = '0;
        repeat (3) tick();
        chk("rst bit1", bus.gtxtest_bit1, 0);
        chk("rst done", bus.gtxtest_done, 0);
        chk("rst all", bus.all_done, 0);
        chk("rst busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();
        cyc = 0;
    endtask

    initial begin
        // 1: both channels lock together
        do_reset();
        bus.ena = 1'b1;
        bus.plllkdet = 2'b11;
        for (int k = 0; k < 34; k++) begin
            tick();
            chk("t1 bit1", bus.gtxtest_bit1, {2{pb(cyc, 3)}});
            chk("t1 done", bus.gtxtest_done, {2{pd(cyc, 3)}});
            chk("t1 all", bus.all_done, cyc >= 32);
            chk("t1 busy", bus.busy, cyc >= 4 && cyc <= 31);
        end

        // 2: ch1 locks 20 cycles after ch0
        do_reset();
        bus.ena = 1'b1;
        bus.plllkdet = 2'b01;
        for (int k = 0; k < 56; k++) begin
            if (cyc == 20) bus.plllkdet = 2'b11;
            tick();
            chk("t2 bit1", bus.gtxtest_bit1,
                {pb(cyc, 23), pb(cyc, 3)});
            chk("t2 done", bus.gtxtest_done,
                {pd(cyc, 23), pd(cyc, 3)});
            chk("t2 all", bus.all_done, cyc >= 52);
            chk("t2 busy", bus.busy, cyc >= 4 && cyc <= 51);
        end

        // 3: ch0 loses lock in 2nd pulse, then relocks
        do_reset();
        bus.ena = 1'b1;
        bus.plllkdet = 2'b11;
        for (int k = 0; k < 70; k++) begin
            if (cyc == 28) bus.plllkdet[0] = 1'b0;
            if (cyc == 35) bus.plllkdet[0] = 1'b1;
            tick();
            chk("t3 bit1", bus.gtxtest_bit1,
                {pb(cyc, 3),
                 (cyc <= 30) ? pb(cyc, 3) :
                 (cyc < 38) ? 1'b0 : pb(cyc, 38)});
            chk("t3 done", bus.gtxtest_done,
                {pd(cyc, 3), (cyc >= 38) && pd(cyc, 38)});
        end

        // 4: TX_RATE[1] change after both done reruns ch1 only
        for (int k = 0; k < 35; k++) begin
            if (cyc == 72) bus.tx_rate[1] = 1'b1;
            tick();
            chk("t4 bit1", bus.gtxtest_bit1, {pb(cyc, 73), 1'b0});
            chk("t4 done", bus.gtxtest_done,
                {(cyc < 73) || pd(cyc, 73), 1'b1});
            chk("t4 all", bus.all_done, !(cyc >= 74 && cyc <= 101));
            chk("t4 busy", bus.busy, cyc >= 74 && cyc <= 101);
        end

        // 5: one-cycle ENA drop during WAIT
        do_reset();
        bus.ena = 1'b1;
        bus.plllkdet = 2'b11;
        for (int k = 0; k < 45; k++) begin
            if (cyc == 10) bus.ena = 1'b0;
            if (cyc == 11) bus.ena = 1'b1;
            tick();
            chk("t5 bit1", bus.gtxtest_bit1,
                {2{(cyc >= 11) && pb(cyc, 12)}});
            chk("t5 done", bus.gtxtest_done,
                {2{(cyc >= 11) && pd(cyc, 12)}});
            chk("t5 busy", bus.busy,
                (cyc >= 4 && cyc <= 11) || (cyc >= 13 && cyc <= 40));
        end

        // 6a: restart coincident with lock loss -> abort wins
        do_reset();
        bus.ena = 1'b1;
        bus.plllkdet = 2'b01;
        for (int k = 0; k < 25; k++) begin
            if (cyc == 20) bus.plllkdet[0] = 1'b0;
            if (cyc == 22) bus.restart[0] = 1'b1;
            if (cyc == 23) bus.restart[0] = 1'b0;
            tick();
            chk("t6 bit1", bus.gtxtest_bit1,
                {1'b0, (cyc <= 22) && pb(cyc, 3)});
            chk("t6 busy", bus.busy, cyc >= 4 && cyc <= 23);
        end

        // 6b: async reset in the middle of a pulse
        bus.plllkdet = 2'b11;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t6 relock", bus.gtxtest_bit1, {2{pb(cyc, 28)}});
        end
        chk("t6 pre", bus.gtxtest_bit1, 2'b11);
        #5;
        rst_n = 1'b0;
        #1;
        chk("t6 rst bit1", bus.gtxtest_bit1, 0);
        chk("t6 rst done", bus.gtxtest_done, 0);
        chk("t6 rst all", bus.all_done, 0);
        chk("t6 rst busy", bus.busy, 0);
        tick();
        chk("t6 hold bit1", bus.gtxtest_bit1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
